// File: rtl/fighter_motion_ctrl.sv
// -----------------------------------------------------------------------------
// fighter_motion_ctrl
//
// Per-fighter position and motion controller feeding the sprite animation
// stage. Keyboard keycodes and opponent hit events are turned into a sprite
// position, a signed per-frame horizontal step and a constant sprite box.
// Everything updates once per video frame, on the rising edge of vsync.
//
// Ports
//   vga_clk        in   1   pixel clock, the only clock
//   reset          in   1   asynchronous, active-high
//   vsync          in   1   frame sync level, sampled on vga_clk
//   keycode        in   8   currently pressed HID keycode, 0 = none
//   hit            in   1   opponent hit (level, sampled on frame tick only)
//   hit_dir        in   1   1 pushes the fighter right, 0 pushes it left
//   spriteX        out  10  sprite left edge
//   spriteY        out  10  sprite top edge
//   spriteWidthL   out  10  constant SPRITE_W
//   spriteHeightU  out  10  constant SPRITE_H
//   motionx        out  10  two's-complement horizontal step applied this frame
//   facing_right   out  1   1 = fighter faces right
//   airborne       out  1   1 while the fighter is in the air
// -----------------------------------------------------------------------------
module fighter_motion_ctrl #(
    parameter int         X_START      = 100,
    parameter int         GROUND_Y     = 300,
    parameter int         SPRITE_W     = 90,
    parameter int         SPRITE_H     = 150,
    parameter int         X_MAX        = 639,
    parameter int         STEP         = 2,
    parameter int         JUMP_V0      = 12,
    parameter int         GRAVITY      = 1,
    parameter int         KNOCK_STEP   = 4,
    parameter int         KNOCK_FRAMES = 8,
    parameter logic [7:0] KEY_LEFT     = 8'h04,
    parameter logic [7:0] KEY_RIGHT    = 8'h07,
    parameter logic [7:0] KEY_JUMP     = 8'h1A
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [7:0] keycode,
    input  logic       hit,
    input  logic       hit_dir,
    output logic [9:0] spriteX,
    output logic [9:0] spriteY,
    output logic [9:0] spriteWidthL,
    output logic [9:0] spriteHeightU,
    output logic [9:0] motionx,
    output logic       facing_right,
    output logic       airborne
);

    // Largest legal left edge: the right edge of the box lands on X_MAX.
    localparam logic signed [10:0] X_RIGHT_LIM = 11'(X_MAX - SPRITE_W + 1);
    localparam logic signed [10:0] Y_GROUND    = 11'(GROUND_Y);
    localparam logic signed [10:0] STEP_S      = 11'(STEP);
    localparam logic signed [10:0] KNOCK_S     = 11'(KNOCK_STEP);
    localparam logic signed [7:0]  VY_TAKEOFF  = 8'(-JUMP_V0);
    localparam logic signed [7:0]  GRAV_S      = 8'(GRAVITY);
    localparam logic [7:0]         KNOCK_LOAD  = 8'(KNOCK_FRAMES);

    typedef enum logic [1:0] {
        GROUND,
        AIR,
        KNOCK
    } state_t;

    state_t             state;
    logic               vsync_d;
    logic signed [7:0]  vy;
    logic [7:0]         knock_cnt;
    logic               knock_dir;

    logic               tick;
    logic               key_left;
    logic               key_right;
    logic               key_jump;
    logic signed [10:0] dx;
    logic signed [10:0] x_sum;
    logic [9:0]         x_next;
    logic [9:0]         x_applied;
    logic signed [10:0] y_sum;
    logic               landing;

    // Keep the sprite box fully on screen horizontally.
    function automatic logic [9:0] clamp_x(input logic signed [10:0] x);
        if (x < 11'sd0) begin
            return 10'd0;
        end else if (x > X_RIGHT_LIM) begin
            return 10'(X_RIGHT_LIM);
        end else begin
            return 10'(x);
        end
    endfunction

    // Top edge never goes above the screen; the ground side is handled by
    // the landing logic because it also changes state.
    function automatic logic [9:0] clamp_y(input logic signed [10:0] y);
        if (y < 11'sd0) begin
            return 10'd0;
        end else begin
            return 10'(y);
        end
    endfunction

    assign spriteWidthL  = 10'(SPRITE_W);
    assign spriteHeightU = 10'(SPRITE_H);

    always_comb begin
        tick      = vsync & ~vsync_d;
        key_left  = (keycode == KEY_LEFT);
        key_right = (keycode == KEY_RIGHT);
        key_jump  = (keycode == KEY_JUMP);

        // Horizontal request for this frame, before clamping.
        dx = 11'sd0;
        case (state)
            GROUND: begin
                if (key_left) begin
                    dx = -STEP_S;
                end else if (key_right) begin
                    dx = STEP_S;
                end
            end
            AIR: begin
                // Horizontal momentum is whatever was moving at takeoff.
                dx = $signed({motionx[9], motionx});
            end
            KNOCK: begin
                dx = knock_dir ? KNOCK_S : -KNOCK_S;
            end
            default: begin
                dx = 11'sd0;
            end
        endcase

        x_sum     = $signed({1'b0, spriteX}) + dx;
        x_next    = clamp_x(x_sum);
        // Report what actually moved, so partial clamps show a reduced step.
        x_applied = 10'($signed({1'b0, x_next}) - $signed({1'b0, spriteX}));

        y_sum     = $signed({1'b0, spriteY}) + $signed({{3{vy[7]}}, vy});
        landing   = (y_sum >= Y_GROUND);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vsync_d      <= 1'b0;
            state        <= GROUND;
            vy           <= 8'sd0;
            knock_cnt    <= 8'd0;
            knock_dir    <= 1'b0;
            spriteX      <= 10'(X_START);
            spriteY      <= 10'(GROUND_Y);
            motionx      <= 10'd0;
            facing_right <= 1'b1;
            airborne     <= 1'b0;
        end else begin
            vsync_d <= vsync;
            if (tick) begin
                if (hit) begin
                    // A hit wins in every state. The hit frame itself does not
                    // move the fighter; the KNOCK_FRAMES following frames do.
                    state     <= KNOCK;
                    knock_cnt <= KNOCK_LOAD;
                    knock_dir <= hit_dir;
                    vy        <= 8'sd0;
                    spriteY   <= 10'(GROUND_Y);
                    motionx   <= 10'd0;
                    airborne  <= 1'b0;
                end else begin
                    case (state)
                        GROUND: begin
                            if (key_jump) begin
                                // Takeoff frame: position and motionx hold.
                                state    <= AIR;
                                vy       <= VY_TAKEOFF;
                                airborne <= 1'b1;
                            end else begin
                                spriteX <= x_next;
                                motionx <= x_applied;
                                if (key_left) begin
                                    facing_right <= 1'b0;
                                end else if (key_right) begin
                                    facing_right <= 1'b1;
                                end
                            end
                        end
                        AIR: begin
                            spriteX <= x_next;
                            if (landing) begin
                                state    <= GROUND;
                                spriteY  <= 10'(GROUND_Y);
                                vy       <= 8'sd0;
                                motionx  <= 10'd0;
                                airborne <= 1'b0;
                            end else begin
                                spriteY <= clamp_y(y_sum);
                                vy      <= vy + GRAV_S;
                                motionx <= x_applied;
                            end
                        end
                        KNOCK: begin
                            // motionx stays 0 so the animation shows idle.
                            spriteX   <= x_next;
                            motionx   <= 10'd0;
                            knock_cnt <= knock_cnt - 8'd1;
                            if (knock_cnt <= 8'd1) begin
                                state <= GROUND;
                            end
                        end
                        default: begin
                            state <= GROUND;
                        end
                    endcase
                end
            end
        end
    end

endmodule
